// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and pointer-width helper for the sync FIFO
package fifo_pkg;

    localparam int DEF_W      = 8;
    localparam int DEF_DP     = 16;
    localparam int DEF_AF_LVL = DEF_DP - 2;
    localparam int DEF_AE_LVL = 2;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - W x DP simple dual-port array, sync write, registered read
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int DP = DEF_DP,
    parameter int AW = ptr_width(DP)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DP];

    // No reset; a same-address read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with occupancy flags and error pulses
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int DP     = DEF_DP,
    parameter int AF_LVL = DP - 2,
    parameter int AE_LVL = DEF_AE_LVL,
    parameter int AW     = ptr_width(DP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_e,
    input  logic [W-1:0]  w_data,
    input  logic          r_e,
    output logic [W-1:0]  r_data,
    output logic          r_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          ovf,
    output logic          udf
);

    localparam logic [AW:0] DP_C = (AW+1)'(DP);
    localparam logic [AW:0] AF_C = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_C = (AW+1)'(AE_LVL);

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         rd_ok;
    logic         wr_ok;
    logic         r_zero;
    logic [W-1:0] ram_q;

    assign empty        = (count == '0);
    assign full         = (count == DP_C);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign rd_ok = r_e && !empty;
    assign wr_ok = w_e && (!full || rd_ok);

    fifo_ram #(.W(W), .DP(DP), .AW(AW)) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok && !rst),
        .wr_addr (wptr[AW-1:0]),
        .wr_data (w_data),
        .rd_en   (rd_ok && !rst),
        .rd_addr (rptr[AW-1:0]),
        .rd_data (ram_q)
    );

    // The array's read register has no reset, so r_data is masked to zero until the first pop.
    assign r_data = r_zero ? '0 : ram_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            r_valid <= 1'b0;
            r_zero  <= 1'b1;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            if (wr_ok && !rd_ok)      count <= count + 1'b1;
            else if (rd_ok && !wr_ok) count <= count - 1'b1;
            r_valid <= rd_ok;
            if (rd_ok) r_zero <= 1'b0;
            ovf <= w_e && !wr_ok;
            udf <= r_e && !rd_ok;
        end
    end

endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - randomized and directed checks of fifo_sync against a queue model
module tb_fifo_sync;

    localparam int W  = 8;
    localparam int DP = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         w_e = 1'b0;
    logic [W-1:0] w_data = '0;
    logic         r_e = 1'b0;
    logic [W-1:0] r_data;
    logic         r_valid;
    logic [4:0]   count;
    logic         full, empty, almost_full, almost_empty, ovf, udf;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] q[$];
    logic [W-1:0] m_rdata = '0;
    bit           m_rvalid = 1'b0;
    bit           m_ovf = 1'b0;
    bit           m_udf = 1'b0;

    fifo_sync dut (
        .clk          (clk),
        .rst          (rst),
        .w_e          (w_e),
        .w_data       (w_data),
        .r_e          (r_e),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf          (ovf),
        .udf          (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model advances on the same edge as the DUT.
    task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit rs);
        bit rd_ok, wr_ok;
        w_e = w; w_data = d; r_e = r; rst = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_rdata = '0; m_rvalid = 0; m_ovf = 0; m_udf = 0;
        end else begin
            rd_ok = r && (q.size() > 0);
            wr_ok = w && ((q.size() < DP) || rd_ok);
            m_rvalid = rd_ok;
            if (rd_ok) m_rdata = q.pop_front();
            if (wr_ok) q.push_back(d);
            m_ovf = w && !wr_ok;
            m_udf = r && !rd_ok;
        end
        @(negedge clk);
        w_e = 0; r_e = 0; rst = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [4:0] diff;
            diff = dut.wptr - dut.rptr;
            chk("count", int'(count), q.size());
            chk("full", int'(full), int'(q.size() == DP));
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("almost_full", int'(almost_full), int'(q.size() >= DP - 2));
            chk("almost_empty", int'(almost_empty), int'(q.size() <= 2));
            chk("r_valid", int'(r_valid), int'(m_rvalid));
            chk("r_data", int'(r_data), int'(m_rdata));
            chk("ovf", int'(ovf), int'(m_ovf));
            chk("udf", int'(udf), int'(m_udf));
            chk("ptr_diff", int'(diff), q.size() % 32);
        end
    end

    initial begin
        int written, got;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk_en = 1;

        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_ae", int'(almost_empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_rvalid", int'(r_valid), 0);
        chk("rst_rdata", int'(r_data), 0);
        step(0, 0, 1, 0);
        chk("idle_udf", int'(udf), 1);
        chk("idle_udf_count", int'(count), 0);
        step(0, 0, 0, 0);
        chk("udf_one_cycle", int'(udf), 0);

        for (int i = 0; i < 16; i++) begin
            step(1, W'(i), 0, 0);
            if (i == 13) chk("af_at_14", int'(almost_full), 1);
            if (i == 12) chk("af_at_13", int'(almost_full), 0);
        end
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 16);
        step(1, 8'hAA, 0, 0);
        chk("fill_ovf", int'(ovf), 1);
        chk("fill_ovf_count", int'(count), 16);

        step(1, 8'h55, 1, 0);
        chk("fullrw_count", int'(count), 16);
        chk("fullrw_ovf", int'(ovf), 0);
        chk("fullrw_data", int'(r_data), 8'h00);
        chk("fullrw_valid", int'(r_valid), 1);
        for (int i = 1; i < 16; i++) begin
            step(0, 0, 1, 0);
            chk("drain_data", int'(r_data), i);
        end
        step(0, 0, 1, 0);
        chk("drain_55", int'(r_data), 8'h55);
        chk("drain_empty", int'(empty), 1);

        step(1, 8'h33, 1, 0);
        chk("emptyrw_udf", int'(udf), 1);
        chk("emptyrw_valid", int'(r_valid), 0);
        chk("emptyrw_count", int'(count), 1);
        step(0, 0, 1, 0);
        chk("emptyrw_data", int'(r_data), 8'h33);

        written = 0; got = 0;
        for (int c = 0; c < 2000 && got < 40; c++) begin
            bit w, r;
            w = (written < 40) && (q.size() < 10) && ((q.size() < 3) || ($urandom_range(0, 1) == 1));
            r = (q.size() > 3 || written == 40) && (q.size() > 0) && $urandom_range(0, 1) == 1;
            step(w, W'(written), r, 0);
            if (r) begin
                chk("wrap_order", int'(r_data), got);
                got++;
            end
            if (w) written++;
        end
        chk("wrap_done", got, 40);

        for (int c = 0; c < 600; c++) begin
            step(bit'($urandom_range(0, 1)), W'($urandom), bit'($urandom_range(0, 1)), 0);
        end

        while (q.size() > 0) step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, W'(8'hC0 + i), 0, 0);
        chk("pre_rst_count", int'(count), 5);
        step(0, 0, 1, 1);
        chk("midrst_count", int'(count), 0);
        chk("midrst_empty", int'(empty), 1);
        chk("midrst_valid", int'(r_valid), 0);
        chk("midrst_data", int'(r_data), 0);
        chk("midrst_ovf", int'(ovf), 0);
        chk("midrst_udf", int'(udf), 0);
        step(0, 0, 0, 0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
